// File: rtl/calyx_mem_pkg.sv
// Shared types for Calyx std_mem_d1 helper blocks.
// Covers the copy engine's state encoding and its per-word timing.
package calyx_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StWait,
    StDone
  } copy_state_e;

  // READ, WRITE and one WAIT cycle against a memory whose done follows write_en by one cycle.
  localparam int unsigned CopyCyclesPerWord = 3;

  // Nominal go-to-done latency with a one-cycle destination done.
  function automatic int unsigned copy_cycles(input int unsigned len, input logic err);
    return (err || len == 0) ? 1 : CopyCyclesPerWord * len + 1;
  endfunction

endpackage

// File: rtl/std_mem_copy_d1.sv
// Copies len words between two std_mem_d1 memories under a Calyx go/done handshake.
// One word per READ/WRITE/WAIT pass; WAIT stretches until the destination reports done.
module std_mem_copy_d1
  import calyx_mem_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter int unsigned Size    = 16,
  parameter int unsigned IdxSize = 4
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               go_i,
  input  logic [IdxSize-1:0] src_base_i,
  input  logic [IdxSize-1:0] dst_base_i,
  input  logic [IdxSize:0]   len_i,
  output logic [IdxSize-1:0] src_addr0_o,
  input  logic [Width-1:0]   src_read_data_i,
  output logic [IdxSize-1:0] dst_addr0_o,
  output logic [Width-1:0]   dst_write_data_o,
  output logic               dst_write_en_o,
  input  logic               dst_done_i,
  output logic               done_o,
  output logic               error_o
);

  localparam int unsigned SumW = IdxSize + 2;

  copy_state_e        state_q;
  logic [IdxSize:0]   cnt_q;
  logic [IdxSize-1:0] src_base_q;
  logic [IdxSize-1:0] dst_base_q;
  logic [IdxSize:0]   len_q;
  logic [IdxSize-1:0] src_addr0_q;
  logic [IdxSize-1:0] dst_addr0_q;
  logic [Width-1:0]   wdata_q;
  logic               wen_q;
  logic               done_q;
  logic               error_q;

  logic [SumW-1:0]  src_end;
  logic [SumW-1:0]  dst_end;
  logic             range_err;
  logic [IdxSize:0] cnt_inc;

  // Sums are widened so that base + len can never wrap before the comparison.
  assign src_end   = SumW'(src_base_i) + SumW'(len_i);
  assign dst_end   = SumW'(dst_base_i) + SumW'(len_i);
  assign range_err = (src_end > SumW'(Size)) || (dst_end > SumW'(Size));
  assign cnt_inc   = cnt_q + (IdxSize + 1)'(1);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      len_q       <= '0;
      src_addr0_q <= '0;
      dst_addr0_q <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wen_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go_i) begin
            src_base_q <= src_base_i;
            dst_base_q <= dst_base_i;
            len_q      <= len_i;
            cnt_q      <= '0;
            if (range_err) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else if (len_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q     <= StRead;
              src_addr0_q <= src_base_i;
            end
          end
        end
        StRead: begin
          // Source read_data is combinational on addr0, so it is valid by the end of READ.
          wdata_q     <= src_read_data_i;
          dst_addr0_q <= dst_base_q + cnt_q[IdxSize-1:0];
          wen_q       <= 1'b1;
          state_q     <= StWrite;
        end
        StWrite: begin
          state_q <= StWait;
        end
        StWait: begin
          if (dst_done_i) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == len_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q     <= StRead;
              src_addr0_q <= src_base_q + cnt_inc[IdxSize-1:0];
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign src_addr0_o      = src_addr0_q;
  assign dst_addr0_o      = dst_addr0_q;
  assign dst_write_data_o = wdata_q;
  assign dst_write_en_o   = wen_q;
  assign done_o           = done_q;
  assign error_o          = error_q;

endmodule
